desconcatenador: RTL
====================

Name: desconcatenador

Overview:
- Opposite end of the block-assembly path: accepts a complete 128-bit block (96-bit payload and 32-bit nonce) over a valid/ready handshake.
- Emits the block as a stream of 32-bit words, most-significant word first, to the downstream word-serial hash datapath.
- Also holds the split-out payload and nonce fields stable for result reporting.

Parameters:
- BLOCK_W, 128, width of the input block; must be a multiple of WORD_W.
- WORD_W, 32, output word width and nonce width.
- NWORDS (localparam), BLOCK_W/WORD_W = 4, words per block.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- blk_valid  input  1  bloque_in holds a valid block.
- blk_ready  output  1  block accepted when blk_valid && blk_ready.
- bloque_in  input  BLOCK_W  block; [127:32] payload, [31:0] nonce.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  downstream accepts word when word_valid && word_ready.
- word_out  output  WORD_W  current word.
- word_idx  output  2 ($clog2(NWORDS))  index of current word, 0 = MSB word.
- word_last  output  1  high with word_valid on word NWORDS-1.
- entrada_out  output  BLOCK_W-WORD_W  payload of last accepted block.
- nonce_out  output  WORD_W  nonce of last accepted block.
- busy  output  1  high in SEND.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - State = IDLE; shift register, word_idx, entrada_out and nonce_out are cleared to 0.
  - word_valid = 0, word_last = 0, busy = 0, blk_ready = 1 once reset is released.
  - Reset mid-block abandons the block; no partial words are emitted after release.
- FSM has two states, IDLE and SEND.
- IDLE:
  - blk_ready = 1, word_valid = 0.
  - On blk_valid && blk_ready: capture bloque_in into the shift register, entrada_out <= bloque_in[127:32], nonce_out <= bloque_in[31:0], word_idx <= 0, go to SEND.
- SEND:
  - word_valid = 1 and word_out = shift register [127:96].
  - word_last = (word_idx == NWORDS-1); busy = 1; blk_ready = 0 (unless the macro below is defined).
  - Word handshake without last: shift left by WORD_W (zero fill) and increment word_idx.
  - Word handshake with word_last: return to IDLE, word_idx <= 0.
- Latency: first word is valid 1 cycle after the block handshake. With word_ready held high, a block occupies 4 consecutive cycles; without the macro, throughput is 1 block per 5 cycles.
- Stall (word_valid && !word_ready): word_out, word_idx and word_last hold unchanged indefinitely.
- Word order: idx0 = [127:96], idx1 = [95:64], idx2 = [63:32], idx3 = nonce [31:0].
- entrada_out and nonce_out change only on a block handshake and stay stable through SEND and IDLE.
- blk_valid while blk_ready = 0 is ignored; the upstream must hold it.
- word_ready has no effect in IDLE.

Optional Feature:
- Macro: DESCONC_PIPE_EN.
- Defined:
  - blk_ready = IDLE || (SEND && word_last && word_ready).
  - If a block handshake coincides with the last-word handshake: load the new block, reset word_idx to 0 and remain in SEND. Word 0 of the new block is presented the very next cycle.
  - Sustained throughput is 1 block per 4 cycles.
- Not defined: blk_ready = 1 only in IDLE, giving one idle bubble per block.

Decomposition:
- Shared package: BLOCK_W, WORD_W and NWORDS constants, plus the state typedef (IDLE, SEND). The same package also serves the assembly-side concatenation block.
- Sub-module: none required. Optionally, the loadable MSB-first shift register with index counter can be split out as desconc_shifter.

Test Plan:
- Block 0x00112233_44556677_8899AABB_DEADBEEF, word_ready=1 -> one cycle later words 00112233, 44556677, 8899AABB, DEADBEEF with idx 0..3 and word_last on idx 3. Then nonce_out=DEADBEEF and entrada_out=00112233_44556677_8899AABB.
- Same block, word_ready low for 3 cycles on idx 1 -> word_out stays 44556677 with idx 1, then the sequence continues with no word lost or duplicated.
- Two back-to-back blocks with blk_valid held high, word_ready=1 -> without the macro, 1 idle cycle between blocks (blk_ready pulses only in IDLE). With DESCONC_PIPE_EN, 8 contiguous valid words.
- reset_L asserted asynchronously mid-cycle while at idx 2 -> word_valid=0 and outputs zero immediately. After release, blk_ready=1 and no residual words are emitted.
- blk_valid with a new block during SEND (macro off) -> ignored until IDLE; nonce_out unchanged until the new block is accepted.
- word_ready=1 in IDLE with blk_valid=0 -> word_valid stays 0, word_idx stays 0.

Source files
------------

// File: rtl/desconcatenador_pkg.sv
// Shared constants and state type for the block assembly/disassembly path.
package desconcatenador_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NWORDS  = BLOCK_W / WORD_W;
  localparam int unsigned IDX_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned PAY_W   = BLOCK_W - WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/desconcatenador_shifter.sv
// Loadable MSB-first block shift register with word index counter.
module desconcatenador_shifter
  import desconcatenador_pkg::*;
(
  input  logic               clk,
  input  logic               reset_L,
  input  logic               load,
  input  logic               advance,
  input  logic [BLOCK_W-1:0] din,
  output logic [WORD_W-1:0]  word,
  output logic [IDX_W-1:0]   idx,
  output logic               last_c
);

  logic [BLOCK_W-1:0] sr_q;
  logic [IDX_W-1:0]   idx_q;

  // Load wins over advance so a new block can follow the last word directly.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load) begin
      sr_q  <= din;
      idx_q <= '0;
    end else if (advance) begin
      sr_q  <= {sr_q[BLOCK_W-WORD_W-1:0], WORD_W'(0)};
      idx_q <= last_c ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign last_c = (idx_q == IDX_W'(NWORDS - 1));
  assign word   = sr_q[BLOCK_W-1 -: WORD_W];
  assign idx    = idx_q;

endmodule

// File: rtl/desconcatenador.sv
// Splits an accepted 128-bit block into MSB-first 32-bit words.
// Define DESCONC_PIPE_EN to accept the next block on the last-word handshake.
module desconcatenador
  import desconcatenador_pkg::*;
(
  input  logic               clk,
  input  logic               reset_L,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] bloque_in,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [WORD_W-1:0]  word_out,
  output logic [IDX_W-1:0]   word_idx,
  output logic               word_last,
  output logic [PAY_W-1:0]   entrada_out,
  output logic [WORD_W-1:0]  nonce_out,
  output logic               busy
);

  state_t state_q, state_d;
  logic   load, advance, last_c;

  desconcatenador_shifter u_shifter (
    .clk     (clk),
    .reset_L (reset_L),
    .load    (load),
    .advance (advance),
    .din     (bloque_in),
    .word    (word_out),
    .idx     (word_idx),
    .last_c  (last_c)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (word_ready) begin
          if (!last_c) begin
            advance = 1'b1;
          end else begin
`ifdef DESCONC_PIPE_EN
            if (blk_valid) begin
              load = 1'b1;
            end else begin
              advance = 1'b1;
              state_d = IDLE;
            end
`else
            advance = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
    endcase
  end

  // Reported fields only move on a block handshake.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      entrada_out <= '0;
      nonce_out   <= '0;
    end else if (load) begin
      entrada_out <= bloque_in[BLOCK_W-1:WORD_W];
      nonce_out   <= bloque_in[WORD_W-1:0];
    end
  end

`ifdef DESCONC_PIPE_EN
  assign blk_ready = (state_q == IDLE) || (last_c && word_ready);
`else
  assign blk_ready = (state_q == IDLE);
`endif

  assign word_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign word_last  = (state_q == SEND) && last_c;

endmodule
